// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine
// Responder for the movement controller's draw handshake. On drawBG or
// drawChar it scans one SPRITE_W x SPRITE_H block starting at the latched
// top-left coordinate. Background pixels are streamed from the background
// ROM; character pixels come from the sprite ROM, and the colour key is
// skipped. Each pixel is sent to the VGA plot port. When the block is
// finished, doneBG/doneChar is held high until the request drops.
module sprite_draw_engine #(
    parameter int SPRITE_W = 8,
    parameter int SPRITE_H = 8,
    parameter int COLOUR_W = 9,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 9'h1FF,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    localparam int N  = SPRITE_W * SPRITE_H,
    localparam int AW = $clog2(N),
    localparam int CW = $clog2(SPRITE_W)
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                drawBG,
    input  logic                drawChar,
    input  logic [8:0]          xCoordinate,
    input  logic [7:0]          yCoordinate,
    output logic                doneBG,
    output logic                doneChar,
    output logic [16:0]         bgAddr,
    input  logic [COLOUR_W-1:0] bgData,
    output logic [AW-1:0]       spriteAddr,
    input  logic [COLOUR_W-1:0] spriteData,
    output logic [8:0]          vgaX,
    output logic [7:0]          vgaY,
    output logic [COLOUR_W-1:0] vgaColour,
    output logic                plot
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_FLUSH, S_DONE} state_t;

    state_t            r_state;
    logic [8:0]        r_x0;
    logic [7:0]        r_y0;
    logic              r_modeChar;
    logic [AW-1:0]     r_pix;
    logic              r_pvalid;
    logic [9:0]        r_px;
    logic [8:0]        r_py;
    logic              r_doneBG;
    logic              r_doneChar;

    logic [CW-1:0]       w_col;
    logic [AW-CW-1:0]    w_row;
    logic [9:0]          w_ax;
    logic [8:0]          w_ay;
    logic [COLOUR_W-1:0] w_colour;

    // Powers-of-two sizes let one pixel counter double as {row, col}.
    assign w_col = r_pix[CW-1:0];
    assign w_row = r_pix[AW-1:CW];

    // Widened so that off-screen pixels overflow into the clip compare.
    assign w_ax = {1'b0, r_x0} + 10'(w_col);
    assign w_ay = {1'b0, r_y0} + 9'(w_row);

    assign bgAddr     = 17'(w_ay) * 17'd320 + 17'(w_ax);
    assign spriteAddr = r_pix;

    // The ROM's output register acts as the colour half of the plot
    // stage. Only the coordinate/valid pipe is registered here, so
    // colour and strobe line up with the same pixel.
    assign w_colour  = r_modeChar ? spriteData : bgData;
    assign vgaX      = r_px[8:0];
    assign vgaY      = r_py[7:0];
    assign vgaColour = r_pvalid ? w_colour : '0;
    assign plot      = r_pvalid
                    && (r_px < 10'(SCREEN_W))
                    && (r_py < 9'(SCREEN_H))
                    && !(r_modeChar && (w_colour == TRANSPARENT));

    assign doneBG   = r_doneBG;
    assign doneChar = r_doneChar;

    // Handshake FSM, pixel counter and coordinate/valid pipeline.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state    <= S_IDLE;
            r_x0       <= '0;
            r_y0       <= '0;
            r_modeChar <= 1'b0;
            r_pix      <= '0;
            r_pvalid   <= 1'b0;
            r_px       <= '0;
            r_py       <= '0;
            r_doneBG   <= 1'b0;
            r_doneChar <= 1'b0;
        end else begin
            r_pvalid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (drawBG || drawChar) begin
                        r_x0       <= xCoordinate;
                        r_y0       <= yCoordinate;
                        r_modeChar <= !drawBG;
                        r_pix      <= '0;
                        r_state    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    r_pvalid <= 1'b1;
                    r_px     <= w_ax;
                    r_py     <= w_ay;
                    r_pix    <= r_pix + AW'(1);
                    if (r_pix == AW'(N - 1)) begin
                        r_state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    r_doneBG   <= !r_modeChar;
                    r_doneChar <= r_modeChar;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    if (!(r_modeChar ? drawChar : drawBG)) begin
                        r_doneBG   <= 1'b0;
                        r_doneChar <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb_sprite_draw_engine
// Scoreboard bench: each block request pushes its expected plots, tagged
// with their cycle, and a monitor pops one entry per plot strobe.
module tb_sprite_draw_engine;

    logic        clock = 1'b0;
    logic        resetn;
    logic        drawBG;
    logic        drawChar;
    logic [8:0]  xCoordinate;
    logic [7:0]  yCoordinate;
    logic        doneBG;
    logic        doneChar;
    logic [16:0] bgAddr;
    logic [8:0]  bgData;
    logic [5:0]  spriteAddr;
    logic [8:0]  spriteData;
    logic [8:0]  vgaX;
    logic [7:0]  vgaY;
    logic [8:0]  vgaColour;
    logic        plot;

    typedef struct {
        int cyc;
        int x;
        int y;
        int col;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_plots = 0;
    logic [8:0] spr_rom [64];

    sprite_draw_engine #(
        .SPRITE_W(8),
        .SPRITE_H(8),
        .COLOUR_W(9),
        .TRANSPARENT(9'h1FF),
        .SCREEN_W(320),
        .SCREEN_H(240)
    ) dut (
        .clock(clock),
        .resetn(resetn),
        .drawBG(drawBG),
        .drawChar(drawChar),
        .xCoordinate(xCoordinate),
        .yCoordinate(yCoordinate),
        .doneBG(doneBG),
        .doneChar(doneChar),
        .bgAddr(bgAddr),
        .bgData(bgData),
        .spriteAddr(spriteAddr),
        .spriteData(spriteData),
        .vgaX(vgaX),
        .vgaY(vgaY),
        .vgaColour(vgaColour),
        .plot(plot)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [8:0] bg_colour(input int a);
        return 9'((a * 5 + 11) % 512);
    endfunction

    // Synchronous ROMs with one cycle of latency.
    always @(posedge clock) begin
        bgData     <= bg_colour(int'(bgAddr));
        spriteData <= spr_rom[spriteAddr];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop one expectation per plot strobe; check done exclusivity.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            checks++;
            if (doneBG && doneChar) begin
                errors++;
                $display("FAIL done_overlap: doneBG=%0d doneChar=%0d required not both (cycle %0d)",
                         doneBG, doneChar, cyc);
            end
            if (plot) begin
                n_plots++;
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL plot_unexpected: x=%0d y=%0d c=%0d at cycle %0d, none required",
                             vgaX, vgaY, vgaColour, cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e.cyc || int'(vgaX) != e.x || int'(vgaY) != e.y
                        || int'(vgaColour) != e.col) begin
                        errors++;
                        $display("FAIL plot: got cyc=%0d x=%0d y=%0d c=%0d expected cyc=%0d x=%0d y=%0d c=%0d",
                                 cyc, vgaX, vgaY, vgaColour, e.cyc, e.x, e.y, e.col);
                    end
                end
            end
        end
    end

    task automatic push_expect(input bit isChar, input int x0, input int y0,
                               input int t, input int last_k);
        exp_t e;
        for (int k = 0; k <= last_k; k++) begin
            e.x   = x0 + (k % 8);
            e.y   = y0 + (k / 8);
            e.cyc = t + 2 + k;
            e.col = isChar ? int'(spr_rom[k]) : int'(bg_colour(e.y * 320 + e.x));
            if (e.x < 320 && e.y < 240 && !(isChar && e.col == 511)) q.push_back(e);
        end
    endtask

    task automatic issue(input bit bg, input bit ch, input int x, input int y, output int t);
        @(posedge clock);
        #1;
        xCoordinate = 9'(x);
        yCoordinate = 8'(y);
        drawBG      = bg;
        drawChar    = ch;
        n_plots     = 0;
        t           = cyc;
    endtask

    task automatic wait_done(input bit isChar, input int t, input int drop_at,
                             input int exp_plots, input string tag);
        int at;
        int other_seen;
        at = -1;
        other_seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if ((isChar ? doneChar : doneBG) == 1'b1) begin
                at = cyc;
                break;
            end
            if ((isChar ? doneBG : doneChar) == 1'b1) other_seen = 1;
            @(posedge clock);
            #1;
            if (drop_at > 0 && cyc == t + drop_at) begin
                if (isChar) drawChar = 1'b0;
                else        drawBG   = 1'b0;
            end
        end
        chk({tag, "_done_cycle"}, at, t + 66);
        chk({tag, "_other_done"}, other_seen, 0);
        if ((isChar ? drawChar : drawBG) == 1'b1) begin
            @(posedge clock);
            #1;
            if (isChar) drawChar = 1'b0;
            else        drawBG   = 1'b0;
            @(negedge clock);
            chk({tag, "_done_hold"}, int'(isChar ? doneChar : doneBG), 1);
        end
        @(negedge clock);
        chk({tag, "_done_release"}, int'(isChar ? doneChar : doneBG), 0);
        chk({tag, "_plots"}, n_plots, exp_plots);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        int t2;
        for (int i = 0; i < 64; i++) spr_rom[i] = 9'(i * 3 + 1);
        spr_rom[0]  = 9'h1FF; spr_rom[7]  = 9'h1FF; spr_rom[9]  = 9'h1FF;
        spr_rom[18] = 9'h1FF; spr_rom[27] = 9'h1FF; spr_rom[36] = 9'h1FF;
        spr_rom[45] = 9'h1FF; spr_rom[54] = 9'h1FF; spr_rom[62] = 9'h1FF;
        spr_rom[63] = 9'h1FF;

        resetn = 1'b0;
        drawBG = 1'b0;
        drawChar = 1'b0;
        xCoordinate = '0;
        yCoordinate = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_plot", int'(plot), 0);
        chk("rst_doneBG", int'(doneBG), 0);
        chk("rst_doneChar", int'(doneChar), 0);
        chk("rst_vgaX", int'(vgaX), 0);
        chk("rst_vgaY", int'(vgaY), 0);
        chk("rst_vgaColour", int'(vgaColour), 0);
        chk("rst_bgAddr", int'(bgAddr), 0);
        chk("rst_spriteAddr", int'(spriteAddr), 0);
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Background block fully on screen.
        issue(1'b1, 1'b0, 95, 221, t);
        push_expect(1'b0, 95, 221, t, 63);
        @(negedge clock);
        @(negedge clock);
        chk("bg_first_bgAddr", int'(bgAddr), 70815);
        wait_done(1'b0, t, 0, 64, "bg");

        // Character block with ten transparent sprite entries.
        issue(1'b0, 1'b1, 120, 196, t);
        push_expect(1'b1, 120, 196, t, 63);
        wait_done(1'b1, t, 0, 54, "char");

        // Background block clipped at the bottom-right screen corner.
        issue(1'b1, 1'b0, 316, 236, t);
        push_expect(1'b0, 316, 236, t, 63);
        wait_done(1'b0, t, 0, 16, "clip");

        // Both requests high: BG first, then CHAR once drawBG drops.
        issue(1'b1, 1'b1, 200, 100, t);
        push_expect(1'b0, 200, 100, t, 63);
        wait_done(1'b0, t, 0, 64, "both_bg");
        t2 = cyc;
        n_plots = 0;
        push_expect(1'b1, 200, 100, t2, 63);
        wait_done(1'b1, t2, 0, 54, "both_char");

        // Reset during the scan, then a fresh block from pixel 0.
        issue(1'b1, 1'b0, 10, 20, t);
        push_expect(1'b0, 10, 20, t, 28);
        while (cyc < t + 30) begin
            @(posedge clock);
            #1;
        end
        resetn = 1'b0;
        drawBG = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("midrst_plot", int'(plot), 0);
        chk("midrst_doneBG", int'(doneBG), 0);
        chk("midrst_bgAddr", int'(bgAddr), 0);
        chk("midrst_spriteAddr", int'(spriteAddr), 0);
        chk("midrst_vgaColour", int'(vgaColour), 0);
        chk("midrst_plots", n_plots, 29);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        issue(1'b1, 1'b0, 10, 20, t);
        push_expect(1'b0, 10, 20, t, 63);
        @(negedge clock);
        @(negedge clock);
        chk("restart_bgAddr", int'(bgAddr), 6410);
        chk("restart_spriteAddr", int'(spriteAddr), 0);
        wait_done(1'b0, t, 0, 64, "restart");

        // drawChar dropped mid-scan: the block still completes, one-cycle done.
        issue(1'b0, 1'b1, 40, 50, t);
        push_expect(1'b1, 40, 50, t, 63);
        wait_done(1'b1, t, 10, 54, "drop");

        repeat (4) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
